// File: rtl/board_renderer_if.sv
// rtl/board_renderer_if.sv - request/map inputs and pixel output bundle for board_renderer
interface board_renderer_if #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int X_W  = 8,
  parameter int Y_W  = 7
);
  localparam int N  = COLS * ROWS;
  localparam int TW = (N > 1) ? $clog2(N) : 1;

  logic           start;
  logic           mode;
  logic [TW-1:0]  tile_sel;
  logic [N-1:0]   mine_map;
  logic [N-1:0]   flag_map;
  logic [N-1:0]   step_map;
  logic [N-1:0]   pos_map;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     color;
  logic           plot;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    output start, mode, tile_sel, mine_map, flag_map, step_map, pos_map,
    input  x, y, color, plot, busy, done, err
  );

  modport slave (
    input  start, mode, tile_sel, mine_map, flag_map, step_map, pos_map,
    output x, y, color, plot, busy, done, err
  );
endinterface

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - rasterises board tiles (full board or one tile) into one pixel per cycle
module board_renderer #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int TILE_W = 19,
  parameter int TILE_H = 14,
  parameter int X_W    = 8,
  parameter int Y_W    = 7
) (
  input  logic            clk,
  input  logic            reset,
  board_renderer_if.slave bus
);
  localparam int N   = COLS * ROWS;
  localparam int TW  = (N > 1) ? $clog2(N) : 1;
  localparam int PXW = $clog2(TILE_W);
  localparam int PYW = $clog2(TILE_H);
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
  state_t state;

  logic [N-1:0]   s_mine, s_flag, s_step, s_pos;
  logic           s_mode;
  logic [TW-1:0]  s_sel;

  logic [TW-1:0]  idx;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [X_W-1:0] xb;
  logic [Y_W-1:0] yb;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;

  logic [TW-1:0]  n_idx;
  logic [CW-1:0]  n_col;
  logic [RW-1:0]  n_row;
  logic [X_W-1:0] n_xb;
  logic [Y_W-1:0] n_yb;
  logic [PXW-1:0] n_px;
  logic [PYW-1:0] n_py;
  logic           n_m, n_f, n_s, n_p;
  logic [2:0]     n_color;

  logic [TW-1:0]  st_idx;
  logic [TW-1:0]  last_idx;
  logic           bad_sel, last_pix, advance;
  int             r_sel, c_sel;

  function automatic logic [2:0] pix_color(input logic m, input logic f, input logic s,
                                            input logic p, input int cx, input int cy);
    logic border;
    border = (cx == 0) || (cx == TILE_W - 1) || (cy == 0) || (cy == TILE_H - 1);
    if (p)
      return border ? 3'b011 : 3'b000;
    if (s && m)
      return 3'b100;
    if (s)
      return 3'b010;
    if (f) begin
      if (cx == TILE_W / 2 && cy >= 2 && cy <= TILE_H - 3)
        return 3'b111;
      if (cx >= TILE_W / 2 - 3 && cx < TILE_W / 2 && cy >= 2 && cy <= 4)
        return 3'b100;
    end
    return 3'b000;
  endfunction

  assign st_idx   = bus.mode ? bus.tile_sel : '0;
  assign bad_sel  = bus.mode && (int'(bus.tile_sel) >= N);
  assign last_idx = s_mode ? s_sel : TW'(N - 1);
  assign last_pix = (int'(px) == TILE_W - 1) && (int'(py) == TILE_H - 1) && (idx == last_idx);
  assign advance  = ((state == IDLE) && bus.start && !bad_sel) || ((state == DRAW) && !last_pix);

  // Starting row/col of the requested tile found by a compare chain rather than a divider
  always_comb begin
    r_sel = 0;
    c_sel = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (int'(st_idx) >= r * COLS) begin
        r_sel = r;
        c_sel = int'(st_idx) - r * COLS;
      end
    end
  end

  // Position and map bits of the pixel to be registered at the next edge
  always_comb begin
    n_idx = idx;
    n_col = col;
    n_row = row;
    n_xb  = xb;
    n_yb  = yb;
    n_px  = px;
    n_py  = py;
    if (state == IDLE) begin
      n_idx = st_idx;
      n_col = CW'(c_sel);
      n_row = RW'(r_sel);
      n_xb  = X_W'(c_sel * TILE_W);
      n_yb  = Y_W'(r_sel * TILE_H);
      n_px  = '0;
      n_py  = '0;
      n_m   = bus.mine_map[st_idx];
      n_f   = bus.flag_map[st_idx];
      n_s   = bus.step_map[st_idx];
      n_p   = bus.pos_map[st_idx];
    end else begin
      if (int'(px) == TILE_W - 1) begin
        n_px = '0;
        if (int'(py) == TILE_H - 1) begin
          n_py  = '0;
          n_idx = idx + 1'b1;
          if (int'(col) == COLS - 1) begin
            n_col = '0;
            n_xb  = '0;
            n_row = row + 1'b1;
            n_yb  = yb + Y_W'(TILE_H);
          end else begin
            n_col = col + 1'b1;
            n_xb  = xb + X_W'(TILE_W);
          end
        end else begin
          n_py = py + 1'b1;
        end
      end else begin
        n_px = px + 1'b1;
      end
      n_m = s_mine[n_idx];
      n_f = s_flag[n_idx];
      n_s = s_step[n_idx];
      n_p = s_pos[n_idx];
    end
    n_color = pix_color(n_m, n_f, n_s, n_p, int'(n_px), int'(n_py));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      s_mine    <= '0;
      s_flag    <= '0;
      s_step    <= '0;
      s_pos     <= '0;
      s_mode    <= 1'b0;
      s_sel     <= '0;
      idx       <= '0;
      col       <= '0;
      row       <= '0;
      xb        <= '0;
      yb        <= '0;
      px        <= '0;
      py        <= '0;
      bus.x     <= '0;
      bus.y     <= '0;
      bus.color <= '0;
      bus.plot  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (advance) begin
        idx       <= n_idx;
        col       <= n_col;
        row       <= n_row;
        xb        <= n_xb;
        yb        <= n_yb;
        px        <= n_px;
        py        <= n_py;
        bus.x     <= n_xb + X_W'(n_px);
        bus.y     <= n_yb + Y_W'(n_py);
        bus.color <= n_color;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bad_sel) begin
              bus.err <= 1'b1;
            end else begin
              state    <= DRAW;
              s_mine   <= bus.mine_map;
              s_flag   <= bus.flag_map;
              s_step   <= bus.step_map;
              s_pos    <= bus.pos_map;
              s_mode   <= bus.mode;
              s_sel    <= bus.tile_sel;
              bus.plot <= 1'b1;
              bus.busy <= 1'b1;
            end
          end
        end
        DRAW: begin
          if (last_pix) begin
            state    <= FINISH;
            bus.plot <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - scoreboard bench for board_renderer against a tile-loop reference model
module tb_board_renderer;
  localparam int COLS   = 8;
  localparam int ROWS   = 8;
  localparam int TILE_W = 19;
  localparam int TILE_H = 14;
  localparam int N      = COLS * ROWS;
  localparam int FRAME  = N * TILE_W * TILE_H;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  board_renderer_if #(.COLS(COLS), .ROWS(ROWS), .X_W(8), .Y_W(7)) bus ();
  board_renderer_if #(.COLS(COLS), .ROWS(7),    .X_W(8), .Y_W(7)) bus2 ();

  board_renderer #(.COLS(COLS), .ROWS(ROWS)) dut  (.clk(clk), .reset(reset), .bus(bus));
  board_renderer #(.COLS(COLS), .ROWS(7))    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  pix_t       exp_q[$];
  int         exp_done  = 0;
  int         tests     = 0;
  int         fails     = 0;
  int         done_seen = 0;
  int         frame_cnt = 0;
  int         pix_fail_prints = 0;
  bit         prev_plot = 1'b0;
  bit         aborting  = 1'b0;
  logic [7:0] first_x, last_x;
  logic [6:0] first_y, last_y;
  logic [2:0] scr [256][128];

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [2:0] ref_color(input bit m, input bit f, input bit s, input bit p,
                                            input int cx, input int cy);
    bit border;
    border = cx == 0 || cx == TILE_W - 1 || cy == 0 || cy == TILE_H - 1;
    if (p) return border ? 3'b011 : 3'b000;
    if (s && m) return 3'b100;
    if (s) return 3'b010;
    if (f && cx == TILE_W / 2 && cy >= 2 && cy <= TILE_H - 3) return 3'b111;
    if (f && cx >= TILE_W / 2 - 3 && cx < TILE_W / 2 && cy >= 2 && cy <= 4) return 3'b100;
    return 3'b000;
  endfunction

  task automatic push_frame(input bit md, input int sel, input logic [N-1:0] mi,
                            input logic [N-1:0] fl, input logic [N-1:0] st, input logic [N-1:0] po);
    int lo, hi;
    pix_t e;
    lo = md ? sel : 0;
    hi = md ? sel : N - 1;
    for (int t = lo; t <= hi; t++)
      for (int cy = 0; cy < TILE_H; cy++)
        for (int cx = 0; cx < TILE_W; cx++) begin
          e.x = 8'((t % COLS) * TILE_W + cx);
          e.y = 7'((t / COLS) * TILE_H + cy);
          e.c = ref_color(mi[t], fl[t], st[t], po[t], cx, cy);
          exp_q.push_back(e);
        end
    exp_done++;
  endtask

  // Monitor: pops the scoreboard on every plot cycle, records the drawn screen
  always @(negedge clk) begin
    pix_t e;
    if (bus.plot) begin
      if (!prev_plot) begin
        frame_cnt = 0;
        first_x = bus.x;
        first_y = bus.y;
      end
      frame_cnt++;
      last_x = bus.x;
      last_y = bus.y;
      scr[bus.x][bus.y] = bus.color;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d with no pixel required", bus.x, bus.y);
      end else begin
        e = exp_q.pop_front();
        if (e !== {bus.x, bus.y, bus.color}) begin
          fails++;
          if (pix_fail_prints < 20)
            $display("FAIL pixel: got x=%0d y=%0d c=%03b required x=%0d y=%0d c=%03b",
                     bus.x, bus.y, bus.color, e.x, e.y, e.c);
          pix_fail_prints++;
        end
      end
    end
    if (prev_plot && !bus.plot && !aborting) begin
      chk("done_after_last_plot", int'(bus.done), 1);
      chk("queue_empty_at_end", exp_q.size(), 0);
    end
    if (bus.done) begin
      chk("done_expected", int'(exp_done > 0), 1);
      if (exp_done > 0) exp_done--;
      done_seen++;
    end
    chk("busy_eq_plot", int'(bus.busy), int'(bus.plot));
    prev_plot = bus.plot;
  end

  task automatic pulse_start(input bit md, input int sel);
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.mode     = md;
    bus.tile_sel = 6'(sel);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int n = 0;
    while (done_seen == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk({name, "_done_count"}, done_seen - d0, 1);
  endtask

  task automatic set_maps(input logic [N-1:0] mi, input logic [N-1:0] fl,
                          input logic [N-1:0] st, input logic [N-1:0] po);
    bus.mine_map = mi;
    bus.flag_map = fl;
    bus.step_map = st;
    bus.pos_map  = po;
  endtask

  function automatic logic [N-1:0] rnd_map();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [N-1:0] mi, fl, st, po;
    int d0, sel, n, bad;

    bus.start = 1'b0; bus.mode = 1'b0; bus.tile_sel = '0;
    set_maps('0, '0, '0, '0);
    bus2.start = 1'b0; bus2.mode = 1'b0; bus2.tile_sel = '0;
    bus2.mine_map = '0; bus2.flag_map = '0; bus2.step_map = '0; bus2.pos_map = '0;

    // Reset wins over a simultaneous start
    reset = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_plot", int'(bus.plot), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_x", int'(bus.x), 0);
    chk("reset_y", int'(bus.y), 0);
    chk("reset_color", int'(bus.color), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_start_after_reset", int'(bus.busy), 0);

    // Full board, empty maps
    d0 = done_seen;
    push_frame(1'b0, 0, '0, '0, '0, '0);
    pulse_start(1'b0, 0);
    wait_done("full_empty", d0, FRAME + 50);
    chk("full_empty_plots", frame_cnt, FRAME);
    chk("full_empty_first_x", int'(first_x), 0);
    chk("full_empty_first_y", int'(first_y), 0);
    chk("full_empty_last_x", int'(last_x), 151);
    chk("full_empty_last_y", int'(last_y), 111);

    // Player tile 9
    set_maps('0, '0, '0, 64'd1 << 9);
    d0 = done_seen;
    push_frame(1'b1, 9, '0, '0, '0, 64'd1 << 9);
    pulse_start(1'b1, 9);
    wait_done("tile9", d0, 400);
    chk("tile9_plots", frame_cnt, TILE_W * TILE_H);
    chk("tile9_first_x", int'(first_x), 19);
    chk("tile9_first_y", int'(first_y), 14);
    chk("tile9_last_x", int'(last_x), 37);
    chk("tile9_last_y", int'(last_y), 27);
    chk("tile9_c_19_14", int'(scr[19][14]), 3);
    chk("tile9_c_37_20", int'(scr[37][20]), 3);
    chk("tile9_c_28_20", int'(scr[28][20]), 0);

    // Flag on tile 0
    set_maps('0, 64'd1, '0, '0);
    d0 = done_seen;
    push_frame(1'b1, 0, '0, 64'd1, '0, '0);
    pulse_start(1'b1, 0);
    wait_done("flag0", d0, 400);
    for (int yy = 2; yy <= 11; yy++) chk($sformatf("flag_pole_9_%0d", yy), int'(scr[9][yy]), 7);
    for (int xx = 6; xx <= 8; xx++)
      for (int yy = 2; yy <= 4; yy++) chk($sformatf("flag_pennant_%0d_%0d", xx, yy), int'(scr[xx][yy]), 4);
    chk("flag_c_0_0", int'(scr[0][0]), 0);

    // Mine plus step on tile 0 (flag also set; step+mine outranks it)
    set_maps(64'd1, 64'd1, 64'd1, '0);
    d0 = done_seen;
    push_frame(1'b1, 0, 64'd1, 64'd1, 64'd1, '0);
    pulse_start(1'b1, 0);
    wait_done("mine_step", d0, 400);
    bad = 0;
    for (int xx = 0; xx < TILE_W; xx++)
      for (int yy = 0; yy < TILE_H; yy++) if (scr[xx][yy] !== 3'b100) bad++;
    chk("mine_step_non100_pixels", bad, 0);

    // Random single tiles with random maps
    for (int i = 0; i < 10; i++) begin
      mi = rnd_map(); fl = rnd_map(); st = rnd_map(); po = rnd_map() & rnd_map();
      sel = (i == 0) ? N - 1 : int'($urandom_range(0, N - 1));
      set_maps(mi, fl, st, po);
      d0 = done_seen;
      push_frame(1'b1, sel, mi, fl, st, po);
      pulse_start(1'b1, sel);
      wait_done($sformatf("rand_tile%0d", sel), d0, 400);
    end

    // Out-of-range tile on the 56-tile instance
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? 56 : ((i == 1) ? 63 : int'($urandom_range(56, 63)));
      @(posedge clk);
      #1;
      bus2.start = 1'b1; bus2.mode = 1'b1; bus2.tile_sel = 6'(sel);
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      @(negedge clk);
      chk($sformatf("err_pulse_%0d", sel), int'(bus2.err), 1);
      chk("err_busy", int'(bus2.busy), 0);
      chk("err_plot", int'(bus2.plot), 0);
      @(negedge clk);
      chk("err_one_cycle", int'(bus2.err), 0);
      n = 0;
      repeat (5) begin
        @(negedge clk);
        n += int'(bus2.plot) + int'(bus2.busy) + int'(bus2.done);
      end
      chk("err_quiet", n, 0);
    end
    @(posedge clk);
    #1;
    bus2.start = 1'b1; bus2.mode = 1'b1; bus2.tile_sel = 6'd55;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    @(negedge clk);
    chk("last_valid_tile_no_err", int'(bus2.err), 0);
    chk("last_valid_tile_plot", int'(bus2.plot), 1);
    repeat (300) @(posedge clk);

    // Full frame with maps toggled and start re-pulsed while drawing
    mi = rnd_map(); fl = rnd_map(); st = rnd_map(); po = rnd_map() & rnd_map();
    set_maps(mi, fl, st, po);
    d0 = done_seen;
    push_frame(1'b0, 0, mi, fl, st, po);
    pulse_start(1'b0, 0);
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      set_maps(rnd_map(), rnd_map(), rnd_map(), rnd_map());
      bus.start    = ($urandom_range(0, 15) == 0);
      bus.mode     = 1'($urandom);
      bus.tile_sel = 6'($urandom);
    end
    bus.start = 1'b0;
    wait_done("perturbed", d0, FRAME);
    chk("perturbed_plots", frame_cnt, FRAME);
    repeat (20) @(posedge clk);
    chk("perturbed_single_done", done_seen - d0, 1);

    // Reset at plot cycle 500 aborts the frame
    set_maps('0, '0, '0, '0);
    frame_cnt = 0;
    d0 = done_seen;
    push_frame(1'b0, 0, '0, '0, '0, '0);
    pulse_start(1'b0, 0);
    n = 0;
    while (frame_cnt < 500 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_500", frame_cnt, 500);
    aborting = 1'b1;
    reset = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(bus.plot) + int'(bus.busy) + int'(bus.done);
    end
    chk("abort_outputs_quiet", n, 0);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_done = 0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    aborting = 1'b0;

    mi = rnd_map(); fl = rnd_map(); st = rnd_map(); po = rnd_map() & rnd_map();
    set_maps(mi, fl, st, po);
    d0 = done_seen;
    push_frame(1'b0, 0, mi, fl, st, po);
    pulse_start(1'b0, 0);
    wait_done("restart", d0, FRAME + 50);
    chk("restart_first_x", int'(first_x), 0);
    chk("restart_first_y", int'(first_y), 0);
    chk("restart_plots", frame_cnt, FRAME);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
